uart_tx: RTL
============

# uart_tx

Parametrised UART transmitter with an integrated baud-rate divider and a ready/start handshake. It serialises one DW-bit word per frame: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. It sits between a host-side producer, such as a FIFO or a command sequencer, and the board's TX pin. It replaces the fixed 8N1, DTR-triggered transmitter in the serial path.

## Interface
- BAUD_DIV, default `B115200` (104 at 12 MHz): clock cycles per bit; legal range ≥ 2.
- DW, default 8: data bits per frame; legal range 5..9.
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd. Used only when UART_TX_PARITY_EN is defined.
- clk  in  1  system clock; all logic acts on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- data  in  DW  word to transmit; sampled only on the accept edge.
- start  in  1  request to send `data`.
- ready  out  1  transmitter can accept a word this cycle.
- tx  out  1  serial line; idles high.

## Operation
- Accept: a word is accepted on a rising edge where `start && ready`. `data` is captured into the shift register on that edge. Later changes to `data` do not affect the frame.
- `start` while `ready == 0` is ignored and not queued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after 1 bit time.
  - DATA → PARITY after DW bits when parity is compiled in; otherwise DATA → STOP.
  - PARITY → STOP after 1 bit time.
  - STOP → IDLE after STOP_BITS bit times, or STOP → START when an accept occurs in the final stop cycle.
- Baud counter: `$clog2(BAUD_DIV)` bits. Counts 0..BAUD_DIV-1 while not in IDLE and wraps to 0. The bit ends when the count equals BAUD_DIV-1. The counter is held at 0 in IDLE and cleared on accept.
- Bit counter: counts data bits 0..DW-1 and stop bits 0..STOP_BITS-1.
- tx is registered. It drives 0 in START, shifter[0] in DATA (LSB first), the parity bit in PARITY, and 1 in STOP and IDLE.
- Parity bit = XOR of the captured data, inverted when PARITY_ODD = 1.
- ready is registered. It is 1 in IDLE and in the last clock of the final stop bit; it is 0 otherwise.
- Reset (rstn = 0 at an edge):
  - Next cycle: tx = 1, ready = 0, FSM = IDLE, counters = 0.
  - A frame in progress is aborted with no glitch low.
  - ready rises on the first edge after rstn returns high.
  - start is ignored while rstn = 0.

## Timing
- N = 1 + DW + P + STOP_BITS, where P = 1 when parity is compiled in and 0 otherwise.
- Accept at edge k: tx = 0 from cycle k+1 for exactly BAUD_DIV cycles. Each subsequent bit lasts exactly BAUD_DIV cycles.
- The frame occupies cycles k+1 .. k+N·BAUD_DIV.
- ready = 0 for cycles k+1 .. k+N·BAUD_DIV-1. ready = 1 in cycle k+N·BAUD_DIV.
- Back-to-back: an accept in cycle k+N·BAUD_DIV starts the next start bit at k+N·BAUD_DIV+1, with zero idle gap.
- Without back-to-back, tx stays 1 and ready stays 1 indefinitely.
- Latency from accept edge to start-bit falling edge on tx: 1 clock.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists, P = 1, and PARITY_ODD selects even or odd parity.
- Undefined: no parity logic is synthesised, P = 0, the frame is start + DW data bits + stop bits, and PARITY_ODD is ignored.

## Test plan
- Basic 8N1: BAUD_DIV=4, DW=8, parity off; reset, then start with data=0x4B ("K").
  - Required: tx over cycles 1..40 = 0 | 1,1,0,1,0,0,1,0 | 1, each level held 4 clocks.
  - Required: ready low for cycles 1..39 and high at cycle 40.
- Back-to-back: hold start=1 with 0x55, then 0xAA.
  - Required: the second start bit begins exactly 40 cycles after the first, with no idle high cycle between frames.
- Parity, with UART_TX_PARITY_EN: data=0x4B.
  - PARITY_ODD=0: parity bit = 0.
  - PARITY_ODD=1: parity bit = 1.
  - Required in both cases: frame is 11 bits = 44 clocks.
- Busy and format: pulse start with 0x00 at cycle 10 of a 0x4B frame.
  - Required: 0x4B is unchanged on tx, and no second frame follows.
  - With DW=7 and STOP_BITS=2: 0x7F gives 10 bits = 40 clocks.
- Reset mid-frame: drop rstn for 1 cycle during data bit 3.
  - Required: tx = 1 and ready = 0 on the next cycle, then ready = 1 one cycle after rstn rises.
  - Required: a new start then sends a complete frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for uart_tx: word, start request and ready.
// The producer (FIFO or sequencer) uses the master modport; the transmitter uses slave.
interface uart_tx_if #(
   parameter int DW = 8
);
   logic [DW-1:0] data;
   logic          start;
   logic          ready;

   modport master (
      output data,
      output start,
      input  ready
   );

   modport slave (
      input  data,
      input  start,
      output ready
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DW data bits LSB-first, optional parity, 1 or 2 stop bits.
// Parity is compiled in only when the macro UART_TX_PARITY_EN is defined.
module uart_tx #(
   parameter int BAUD_DIV   = 104,  // 115200 baud at 12 MHz
   parameter int DW         = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic     clk,
   input  logic     rstn,
   uart_tx_if.slave bus,
   output logic     tx
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DW + 1);

   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);
   localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] baud_reg;
   logic [BW-1:0] bit_reg;
   logic [DW-1:0] shift_reg;
   logic          tx_reg;
   logic          ready_reg;
`ifdef UART_TX_PARITY_EN
   logic          parity_reg;
`endif

   logic accept;
   logic bit_end;

   // ready_reg is only high in IDLE or the last stop cycle, so accepts can only happen there.
   assign accept  = bus.start && ready_reg;
   assign bit_end = (baud_reg == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
         ready_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         if (state_reg != IDLE) begin
            baud_reg <= bit_end ? '0 : baud_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               tx_reg    <= 1'b1;
               ready_reg <= 1'b1;
            end

            START: begin
               if (bit_end) begin
                  state_reg <= DATA;
                  bit_reg   <= '0;
                  tx_reg    <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  if (bit_reg == DATA_LAST) begin
                     bit_reg <= '0;
`ifdef UART_TX_PARITY_EN
                     state_reg <= PARITY;
                     tx_reg    <= parity_reg;
`else
                     state_reg <= STOP;
                     tx_reg    <= 1'b1;
`endif
                  end else begin
                     bit_reg   <= bit_reg + 1'b1;
                     tx_reg    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state_reg <= STOP;
                  bit_reg   <= '0;
                  tx_reg    <= 1'b1;
               end
            end
`endif

            STOP: begin
               tx_reg <= 1'b1;
               // Raise ready one edge early so it is visible during the final stop cycle.
               if (bit_reg == STOP_LAST && baud_reg == BAUD_PRE) begin
                  ready_reg <= 1'b1;
               end
               if (bit_end) begin
                  if (bit_reg == STOP_LAST) begin
                     bit_reg   <= '0;
                     state_reg <= IDLE;
                  end else begin
                     bit_reg <= bit_reg + 1'b1;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
               tx_reg    <= 1'b1;
            end
         endcase

         // An accept overrides whatever the state above scheduled, giving zero-gap frames.
         if (accept) begin
            state_reg <= START;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= bus.data;
            tx_reg    <= 1'b0;
            ready_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= (^bus.data) ^ (PARITY_ODD != 0);
`endif
         end
      end
   end

   assign tx        = tx_reg;
   assign bus.ready = ready_reg;

endmodule
